// File: rtl/pixel_frame_buffer.sv
// Ping-pong frame buffer: captures reader pixels into buf0/buf1 and
// drains full buffers to the display in strict buf0, buf1 order.
module pixel_frame_buffer #(
  parameter int PIXELS = 10000,
  parameter int AW     = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  imageNumber,
  input  logic [31:0] fin,
  output logic        Buf0Empty,
  output logic        Buf1Empty,
  input  logic        rd_en,
  output logic [23:0] rd_data,
  output logic        rd_valid,
  output logic        frame_done
);

  localparam logic [AW-1:0] LAST = AW'(PIXELS - 1);

  typedef enum logic {IDLE, READ} state_t;

  state_t state_q, state_d;

  logic b0e_q, b0e_d;
  logic b1e_q, b1e_d;
  logic pend0_q, pend0_d;
  logic pend1_q, pend1_d;
  logic rsel_q, rsel_d;
  logic rv_q, rv_d;
  logic fd_q, fd_d;
  logic we0, we1, re;

  logic [AW-1:0] wa0_q, wa0_d;
  logic [AW-1:0] wa1_q, wa1_d;
  logic [AW-1:0] ra_q, ra_d;

  logic [23:0] rdat_q, rdat_d;
  logic [23:0] rword;
  logic [23:0] mem0 [PIXELS];
  logic [23:0] mem1 [PIXELS];

  logic unused_fin;
  assign unused_fin = ^fin[31:24];

  assign rword = rsel_q ? mem1[ra_q] : mem0[ra_q];

  always_comb begin
    state_d = state_q;
    b0e_d   = b0e_q;
    b1e_d   = b1e_q;
    wa0_d   = wa0_q;
    wa1_d   = wa1_q;
    ra_d    = ra_q;
    rsel_d  = rsel_q;
    rdat_d  = rdat_q;
    rv_d    = 1'b0;
    fd_d    = 1'b0;
    we0     = 1'b0;
    we1     = 1'b0;
    re      = 1'b0;
    pend0_d = (imageNumber == 3'd1) && b0e_q;
    pend1_d = (imageNumber == 3'd2) && b1e_q;

    // A completing write wins over a same-edge deselect.
    if (b0e_q) begin
      we0 = pend0_q;
      if (pend0_q && wa0_q == LAST) begin
        b0e_d = 1'b0;
        wa0_d = '0;
      end else if (imageNumber != 3'd1) begin
        wa0_d = '0;
      end else if (pend0_q) begin
        wa0_d = wa0_q + 1'b1;
      end
    end

    if (b1e_q) begin
      we1 = pend1_q;
      if (pend1_q && wa1_q == LAST) begin
        b1e_d = 1'b0;
        wa1_d = '0;
      end else if (imageNumber != 3'd2) begin
        wa1_d = '0;
      end else if (pend1_q) begin
        wa1_d = wa1_q + 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (rsel_q ? !b1e_q : !b0e_q) state_d = READ;
      end
      READ: begin
        if (rd_en) begin
          re     = 1'b1;
          rdat_d = rword;
          rv_d   = 1'b1;
          ra_d   = ra_q + 1'b1;
          if (ra_q == LAST) begin
            fd_d    = 1'b1;
            ra_d    = '0;
            rsel_d  = ~rsel_q;
            state_d = IDLE;
            if (rsel_q) b1e_d = 1'b1;
            else        b0e_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      b0e_q   <= 1'b1;
      b1e_q   <= 1'b1;
      pend0_q <= 1'b0;
      pend1_q <= 1'b0;
      wa0_q   <= '0;
      wa1_q   <= '0;
      ra_q    <= '0;
      rsel_q  <= 1'b0;
      rdat_q  <= '0;
      rv_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      b0e_q   <= b0e_d;
      b1e_q   <= b1e_d;
      pend0_q <= pend0_d;
      pend1_q <= pend1_d;
      wa0_q   <= wa0_d;
      wa1_q   <= wa1_d;
      ra_q    <= ra_d;
      rsel_q  <= rsel_d;
      rdat_q  <= rdat_d;
      rv_q    <= rv_d;
      fd_q    <= fd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we0 && !reset) mem0[wa0_q] <= fin[23:0];
    if (we1 && !reset) mem1[wa1_q] <= fin[23:0];
  end

  assign Buf0Empty  = b0e_q;
  assign Buf1Empty  = b1e_q;
  assign rd_data    = rdat_q;
  assign rd_valid   = rv_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_pixel_frame_buffer.sv
// Bench for pixel_frame_buffer with PIXELS=4: reader model feeds fills,
// a scoreboard of stored pixels checks every rd_valid beat in order.
module tb_pixel_frame_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  imageNumber;
  logic [31:0] fin;
  logic        Buf0Empty, Buf1Empty;
  logic        rd_en;
  logic [23:0] rd_data;
  logic        rd_valid, frame_done;

  pixel_frame_buffer #(.PIXELS(4), .AW(2)) dut (
    .clk(clk), .reset(reset), .imageNumber(imageNumber), .fin(fin),
    .Buf0Empty(Buf0Empty), .Buf1Empty(Buf1Empty), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  img;
    logic [23:0] base;
    logic        eb0;
    logic        eb1;
    int          ncyc;
    int          nv;
    int          span;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nvalid, first, last;
  int pcnt  = 0;
  logic exp_sel = 1'b0;
  logic chk_rel = 1'b0;
  logic rel_buf = 1'b0;
  logic [23:0] cnt = '0;
  logic [23:0] q0[$];
  logic [23:0] q1[$];
  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    logic sel;
    logic [23:0] e;
    sel = (imageNumber == 3'd1 && Buf0Empty) ||
          (imageNumber == 3'd2 && Buf1Empty);
    @(posedge clk);
    #1;
    cyc++;
    if (sel) begin
      fin = {8'hA5, cnt};
      cnt++;
    end
    if (chk_rel) begin
      chk("release_empty", rel_buf ? Buf1Empty : Buf0Empty, 1);
      chk_rel = 1'b0;
    end
    if (rd_valid) begin
      nvalid++;
      if (first < 0) first = cyc;
      last = cyc;
      if ((exp_sel ? q1.size() : q0.size()) == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rd_valid: got data %h expected no beat", rd_data);
      end else begin
        e = exp_sel ? q1.pop_front() : q0.pop_front();
        chk("rd_data", rd_data, e);
        chk("frame_done", frame_done, pcnt == 3);
        if (pcnt == 3) begin
          chk_rel = 1'b1;
          rel_buf = exp_sel;
          pcnt    = 0;
          exp_sel = ~exp_sel;
        end else begin
          pcnt++;
        end
      end
    end else if (frame_done) begin
      chk("frame_done_without_valid", frame_done, 0);
    end
  endtask

  task automatic fill(input logic [2:0] img, input logic [23:0] base);
    int n;
    imageNumber = img;
    cnt = base;
    n = 0;
    do begin
      step();
      n++;
    end while ((img == 3'd1 ? Buf0Empty : Buf1Empty) && n < 20);
    chk("fill_cycles", n, 5);
    imageNumber = 3'd0;
    for (int k = 0; k < 4; k++) begin
      if (img == 3'd1) q0.push_back(base + 24'(k));
      else             q1.push_back(base + 24'(k));
    end
  endtask

  task automatic drain(input int ncyc, input int ev, input int espan);
    nvalid = 0;
    first  = -1;
    last   = -1;
    rd_en  = 1'b1;
    repeat (ncyc) step();
    rd_en = 1'b0;
    step();
    chk("valid_count", nvalid, ev);
    if (ev > 0) chk("valid_span", last - first + 1, espan);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    tbl[0] = '{3'd1, 24'h000001, 1'b0, 1'b1, 10, 4, 4};
    tbl[1] = '{3'd2, 24'h000100, 1'b1, 1'b0, 10, 4, 4};
    tbl[2] = '{3'd2, 24'h000200, 1'b1, 1'b0,  6, 0, 0};
    tbl[3] = '{3'd1, 24'h000300, 1'b0, 1'b0, 14, 8, 9};

    reset = 1'b1;
    imageNumber = 3'd0;
    fin = '0;
    rd_en = 1'b0;
    step();
    step();
    chk("rst_buf0empty", Buf0Empty, 1);
    chk("rst_buf1empty", Buf1Empty, 1);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_rd_data", rd_data, 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 4; i++) begin
      fill(tbl[i].img, tbl[i].base);
      chk("fill_buf0empty", Buf0Empty, tbl[i].eb0);
      chk("fill_buf1empty", Buf1Empty, tbl[i].eb1);
      drain(tbl[i].ncyc, tbl[i].nv, tbl[i].span);
    end

    // Partial fill abandoned, then a full refill from address 0.
    imageNumber = 3'd1;
    cnt = 24'h000077;
    step();
    step();
    imageNumber = 3'd0;
    step();
    step();
    chk("abort_buf0empty", Buf0Empty, 1);
    fill(3'd1, 24'h00000A);
    drain(10, 4, 4);

    // Reset while buf1 is being read at address 2.
    fill(3'd1, 24'h000400);
    fill(3'd2, 24'h000500);
    nvalid = 0;
    first  = -1;
    n = 0;
    rd_en = 1'b1;
    while (nvalid < 6 && n < 30) begin
      step();
      n++;
    end
    chk("pre_reset_beats", nvalid, 6);
    reset = 1'b1;
    rd_en = 1'b0;
    step();
    chk("midrd_rd_valid", rd_valid, 0);
    chk("midrd_buf0empty", Buf0Empty, 1);
    chk("midrd_buf1empty", Buf1Empty, 1);
    chk("midrd_frame_done", frame_done, 0);
    reset = 1'b0;
    q0.delete();
    q1.delete();
    exp_sel = 1'b0;
    pcnt = 0;
    chk_rel = 1'b0;
    step();
    fill(3'd1, 24'h000600);
    drain(10, 4, 4);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
